// File: rtl/id_ex_stage_pkg.sv
// Shared ID/EX definitions: ALU op encodings, operand-select codes and the
// control bundle carried through the ID/EX register.
package id_ex_stage_pkg;

  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned A_SEL_W  = 2;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [A_SEL_W-1:0] {
    A_SEL_RS1  = 2'd0,
    A_SEL_PC   = 2'd1,
    A_SEL_ZERO = 2'd2,
    A_SEL_RSVD = 2'd3
  } a_sel_e;

  typedef enum logic {
    B_SEL_RS2 = 1'b0,
    B_SEL_IMM = 1'b1
  } b_sel_e;

  typedef struct packed {
    logic [ALU_OP_W-1:0] alu_op;
    logic [A_SEL_W-1:0]  a_sel;
    logic                b_sel;
    logic                reg_we;
    logic                mem_re;
    logic                mem_we;
  } id_ex_ctrl_t;

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// Per-operand bypass select: MEM beats WB beats the stored value; x0 is
// always zero. Flags a MEM-stage load that this operand still waits on.
module id_ex_stage_fwd_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5
) (
  input  logic [RA_W-1:0] rs,
  input  logic            used,
  input  logic [XLEN-1:0] stored,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_reg_we,
  input  logic            mem_mem_re,
  input  logic [XLEN-1:0] mem_result,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_reg_we,
  input  logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] value_c,
  output logic            pending_c
);

  logic rs_zero;

  always_comb begin
    rs_zero   = (rs == RA_W'(0));
    value_c   = stored;
    pending_c = used && !rs_zero && mem_reg_we && mem_mem_re && (mem_rd == rs);
    if (rs_zero) begin
      value_c = '0;
    end else if (mem_reg_we && !mem_mem_re && (mem_rd == rs)) begin
      value_c = mem_result;
    end else if (wb_reg_we && (wb_rd == rs)) begin
      value_c = wb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded instructions, forwards from
// MEM/WB, inserts load-use bubbles and drives ALU operands to EX.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     RA_W     = 5,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic [3:0]      id_alu_op,
  input  logic [1:0]      id_a_sel,
  input  logic            id_b_sel,
  input  logic            id_reg_we,
  input  logic            id_mem_re,
  input  logic            id_mem_we,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_reg_we,
  input  logic            mem_mem_re,
  input  logic [XLEN-1:0] mem_result,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_reg_we,
  input  logic [XLEN-1:0] wb_result,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] ex_store_data,
  output logic [XLEN-1:0] ex_pc,
  output logic [RA_W-1:0] ex_rd,
  output logic            ex_reg_we,
  output logic            ex_mem_re,
  output logic            ex_mem_we
);

  logic            valid_q,    valid_d;
  logic [XLEN-1:0] pc_q,       pc_d;
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;
  logic [XLEN-1:0] imm_q,      imm_d;
  logic [RA_W-1:0] rs1_q,      rs1_d;
  logic [RA_W-1:0] rs2_q,      rs2_d;
  logic [RA_W-1:0] rd_q,       rd_d;
  id_ex_ctrl_t     ctrl_q,     ctrl_d;

  logic [XLEN-1:0] fwd_rs1, fwd_rs2;
  logic            pend_rs1, pend_rs2;
  logic            rs1_used, rs2_used;
  logic            ex_fire, slot_free, load_use;

  assign rs1_used = (ctrl_q.a_sel == A_SEL_RS1);
  assign rs2_used = (ctrl_q.b_sel == B_SEL_RS2) || ctrl_q.mem_we;

  id_ex_stage_fwd_unit #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
    .rs(rs1_q), .used(rs1_used), .stored(rs1_data_q),
    .mem_rd(mem_rd), .mem_reg_we(mem_reg_we), .mem_mem_re(mem_mem_re),
    .mem_result(mem_result), .wb_rd(wb_rd), .wb_reg_we(wb_reg_we),
    .wb_result(wb_result), .value_c(fwd_rs1), .pending_c(pend_rs1)
  );

  id_ex_stage_fwd_unit #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
    .rs(rs2_q), .used(rs2_used), .stored(rs2_data_q),
    .mem_rd(mem_rd), .mem_reg_we(mem_reg_we), .mem_mem_re(mem_mem_re),
    .mem_result(mem_result), .wb_rd(wb_rd), .wb_reg_we(wb_reg_we),
    .wb_result(wb_result), .value_c(fwd_rs2), .pending_c(pend_rs2)
  );

  // Handshake: the slot frees when empty or when EX takes the instruction.
  always_comb begin
    ex_valid  = valid_q && !(pend_rs1 || pend_rs2);
    ex_fire   = ex_valid && ex_ready;
    slot_free = !valid_q || ex_fire;
    load_use  = valid_q && ctrl_q.mem_re && (rd_q != RA_W'(0)) && ctrl_q.reg_we &&
                id_valid && ((id_rs1 == rd_q) || (id_rs2 == rd_q));
    id_ready  = slot_free && !load_use && !flush;
  end

  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    ctrl_d     = ctrl_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (slot_free && load_use) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (slot_free) begin
      valid_d       = id_valid;
      pc_d          = id_pc;
      rs1_data_d    = id_rs1_data;
      rs2_data_d    = id_rs2_data;
      imm_d         = id_imm;
      rs1_d         = id_rs1;
      rs2_d         = id_rs2;
      rd_d          = id_rd;
      ctrl_d.alu_op = id_alu_op;
      ctrl_d.a_sel  = id_a_sel;
      ctrl_d.b_sel  = id_b_sel;
      ctrl_d.reg_we = id_reg_we;
      ctrl_d.mem_re = id_mem_re;
      ctrl_d.mem_we = id_mem_we;
    end else begin
      // Stalled: absorb producers retiring from MEM/WB before they leave.
      rs1_data_d = fwd_rs1;
      rs2_data_d = fwd_rs2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      pc_q       <= RESET_PC;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      ctrl_q     <= '0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      ctrl_q     <= ctrl_d;
    end
  end

  always_comb begin
    case (ctrl_q.a_sel)
      A_SEL_RS1: alu_a = fwd_rs1;
      A_SEL_PC:  alu_a = pc_q;
      default:   alu_a = '0;
    endcase
    alu_b = (ctrl_q.b_sel == B_SEL_IMM) ? imm_q : fwd_rs2;
  end

  assign ex_store_data = fwd_rs2;
  assign alu_op        = ctrl_q.alu_op;
  assign ex_pc         = pc_q;
  assign ex_rd         = rd_q;
  assign ex_reg_we     = ctrl_q.reg_we;
  assign ex_mem_re     = ctrl_q.mem_re;
  assign ex_mem_we     = ctrl_q.mem_we;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard scenarios plus a randomized run
// against an instruction-level model of the EX slot.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n, flush, id_valid, id_ready;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_op;
  logic [1:0]  id_a_sel;
  logic        id_b_sel, id_reg_we, id_mem_re, id_mem_we;
  logic [4:0]  mem_rd, wb_rd;
  logic        mem_reg_we, mem_mem_re, wb_reg_we;
  logic [31:0] mem_result, wb_result;
  logic        ex_ready, ex_valid;
  logic [31:0] alu_a, alu_b, ex_store_data, ex_pc;
  logic [3:0]  alu_op;
  logic [4:0]  ex_rd;
  logic        ex_reg_we, ex_mem_re, ex_mem_we;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .RA_W(5), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
    .id_a_sel(id_a_sel), .id_b_sel(id_b_sel), .id_reg_we(id_reg_we),
    .id_mem_re(id_mem_re), .id_mem_we(id_mem_we), .mem_rd(mem_rd),
    .mem_reg_we(mem_reg_we), .mem_mem_re(mem_mem_re), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_reg_we(wb_reg_we), .wb_result(wb_result), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_rd(ex_rd),
    .ex_reg_we(ex_reg_we), .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we)
  );

  // Instruction-level view of whatever sits in the EX slot.
  typedef struct packed {
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  op;
    logic [1:0]  asel;
    logic        bsel, rwe, mre, mwe;
  } slot_t;

  slot_t m;
  bit    mv;

  task automatic clear_inputs();
    flush = 0; id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_alu_op = 0; id_a_sel = 0; id_b_sel = 0;
    id_reg_we = 0; id_mem_re = 0; id_mem_we = 0;
    mem_rd = 0; mem_reg_we = 0; mem_mem_re = 0; mem_result = 0;
    wb_rd = 0; wb_reg_we = 0; wb_result = 0; ex_ready = 1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic set_id(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [3:0] op, input logic [1:0] asel,
                        input logic bsel, input logic rwe, input logic mre, input logic mwe,
                        input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm);
    id_valid = 1; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_alu_op = op;
    id_a_sel = asel; id_b_sel = bsel; id_reg_we = rwe; id_mem_re = mre; id_mem_we = mwe;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    #1;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid: got %0b want 0", ex_valid); end
    checks++; if (alu_op !== 4'd0) begin errors++; $display("FAIL reset_alu_op: got %0d want 0", alu_op); end
    checks++; if (ex_pc !== RST_PC) begin errors++; $display("FAIL reset_ex_pc: got %h want %h", ex_pc, RST_PC); end
    checks++; if ({ex_reg_we, ex_mem_re, ex_mem_we} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {ex_reg_we, ex_mem_re, ex_mem_we}); end
    @(negedge clk); rst_n = 1;
    set_id(32'h100, 5'd1, 5'd2, 5'd3, ALU_SUB, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1, 32'h2, 32'h0);
    @(negedge clk); id_valid = 0; #1;
    checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h100) begin errors++; $display("FAIL reset_pre_fill: got v=%0b pc=%h want v=1 pc=100", ex_valid, ex_pc); end
    #1 rst_n = 0; #1;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_valid: got %0b want 0", ex_valid); end
    checks++; if (alu_op !== 4'd0) begin errors++; $display("FAIL reset_mid_op: got %0d want 0", alu_op); end
    checks++; if (ex_pc !== RST_PC) begin errors++; $display("FAIL reset_mid_pc: got %h want %h", ex_pc, RST_PC); end
    checks++; if (ex_mem_re !== 1'b0) begin errors++; $display("FAIL reset_mid_mem_re: got %0b want 0", ex_mem_re); end
    @(negedge clk); rst_n = 1; #1;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_after: got %0b want 0", ex_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_id(32'h10, 5'd1, 5'd2, 5'd3, ALU_ADD, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd10, 32'd20, 32'h0);
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0: got %0b want 1", id_ready); end
    @(negedge clk);
    set_id(32'h14, 5'd3, 5'd1, 5'd4, ALU_SUB, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd10, 32'h0);
    #1;
    checks++; if (ex_valid !== 1'b1 || alu_a !== 32'd10 || alu_b !== 32'd20 || alu_op !== ALU_ADD) begin errors++; $display("FAIL b2b_add: got v=%0b a=%0d b=%0d op=%0d want 1 10 20 0", ex_valid, alu_a, alu_b, alu_op); end
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1: got %0b want 1", id_ready); end
    @(negedge clk);
    id_valid = 0; mem_rd = 5'd3; mem_reg_we = 1; mem_result = 32'd7; #1;
    checks++; if (ex_valid !== 1'b1 || alu_a !== 32'd7 || alu_b !== 32'd10 || alu_op !== ALU_SUB) begin errors++; $display("FAIL b2b_sub_fwd: got v=%0b a=%0d b=%0d op=%0d want 1 7 10 1", ex_valid, alu_a, alu_b, alu_op); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(32'h20, 5'd1, 5'd0, 5'd5, ALU_ADD, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 32'd4);
    @(negedge clk);
    set_id(32'h24, 5'd5, 5'd0, 5'd6, ALU_ADD, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    #1;
    checks++; if (id_ready !== 1'b0 || ex_valid !== 1'b1) begin errors++; $display("FAIL lu_stall: got rdy=%0b v=%0b want 0 1", id_ready, ex_valid); end
    @(negedge clk);
    mem_rd = 5'd5; mem_reg_we = 1; mem_mem_re = 1; mem_result = 32'h1234; #1;
    checks++; if (ex_valid !== 1'b0 || id_ready !== 1'b1 || ex_mem_re !== 1'b0) begin errors++; $display("FAIL lu_bubble: got v=%0b rdy=%0b mre=%0b want 0 1 0", ex_valid, id_ready, ex_mem_re); end
    @(negedge clk);
    id_valid = 0; mem_reg_we = 0; mem_mem_re = 0; mem_rd = 0;
    wb_rd = 5'd5; wb_reg_we = 1; wb_result = 32'hDEAD_BEEF; #1;
    checks++; if (ex_valid !== 1'b1 || alu_a !== 32'hDEAD_BEEF || alu_b !== 32'h0) begin errors++; $display("FAIL lu_fwd_wb: got v=%0b a=%h b=%h want 1 deadbeef 0", ex_valid, alu_a, alu_b); end
  endtask

  task automatic test_fwd_priority();
    do_reset();
    set_id(32'h40, 5'd8, 5'd0, 5'd9, ALU_ADD, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1111, 32'h0, 32'h0);
    @(negedge clk);
    id_valid = 0; mem_rd = 5'd8; mem_reg_we = 1; mem_result = 32'd5;
    wb_rd = 5'd8; wb_reg_we = 1; wb_result = 32'd9; #1;
    checks++; if (alu_a !== 32'd5) begin errors++; $display("FAIL prio_mem_over_wb: got %0d want 5", alu_a); end
    mem_reg_we = 0; #1;
    checks++; if (alu_a !== 32'd9) begin errors++; $display("FAIL prio_wb_only: got %0d want 9", alu_a); end
    wb_reg_we = 0;
    set_id(32'h44, 5'd0, 5'd0, 5'd10, ALU_OR, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h123, 32'h0, 32'h0);
    mem_rd = 5'd0; mem_reg_we = 1; mem_result = 32'd77;
    @(negedge clk); id_valid = 0; #1;
    checks++; if (ex_valid !== 1'b1 || alu_a !== 32'd0) begin errors++; $display("FAIL prio_x0: got v=%0b a=%0d want 1 0", ex_valid, alu_a); end
  endtask

  task automatic test_stall_refresh();
    do_reset();
    set_id(32'h200, 5'd1, 5'd2, 5'd7, ALU_ADD, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1, 32'h11, 32'h0);
    @(negedge clk);
    set_id(32'h204, 5'd3, 5'd4, 5'd8, ALU_SUB, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h3, 32'h4, 32'h0);
    ex_ready = 0; wb_rd = 5'd2; wb_reg_we = 1; wb_result = 32'h55;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (ex_valid !== 1'b1 || alu_b !== 32'h55 || id_ready !== 1'b0) begin errors++; $display("FAIL stall_cycle%0d: got v=%0b b=%h rdy=%0b want 1 55 0", c, ex_valid, alu_b, id_ready); end
      @(negedge clk);
      wb_reg_we = 0; wb_result = 32'h0;
    end
    ex_ready = 1; #1;
    checks++; if (alu_b !== 32'h55 || id_ready !== 1'b1) begin errors++; $display("FAIL stall_release: got b=%h rdy=%0b want 55 1", alu_b, id_ready); end
    @(negedge clk); id_valid = 0; #1;
    checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h204 || alu_op !== ALU_SUB) begin errors++; $display("FAIL stall_next: got v=%0b pc=%h op=%0d want 1 204 1", ex_valid, ex_pc, alu_op); end
    @(negedge clk); #1;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL stall_no_dup: got %0b want 0", ex_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    set_id(32'h300, 5'd1, 5'd2, 5'd3, ALU_XOR, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1, 32'h2, 32'h0);
    @(negedge clk);
    set_id(32'h304, 5'd1, 5'd2, 5'd4, ALU_AND, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1, 32'h2, 32'h0);
    flush = 1; #1;
    checks++; if (ex_valid !== 1'b1 || id_ready !== 1'b0) begin errors++; $display("FAIL flush_during: got v=%0b rdy=%0b want 1 0", ex_valid, id_ready); end
    @(negedge clk); flush = 0; id_valid = 0; #1;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_kill: got %0b want 0", ex_valid); end
    @(negedge clk); #1;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_not_captured: got %0b want 0", ex_valid); end
  endtask

  function automatic logic [31:0] ref_fwd(input logic [4:0] r, input logic [31:0] stored);
    if (r == 5'd0) return 32'h0;
    if (mem_reg_we && !mem_mem_re && mem_rd == r) return mem_result;
    if (wb_reg_we && wb_rd == r) return wb_result;
    return stored;
  endfunction

  task automatic test_random();
    bit pend, e_valid, free, lu, e_ready;
    logic [31:0] v1, v2, e_a, e_b;
    do_reset();
    mv = 0; m = '0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      id_valid = ($urandom_range(3) != 0);
      id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
      id_rs1 = 5'($urandom_range(7)); id_rs2 = 5'($urandom_range(7)); id_rd = 5'($urandom_range(7));
      id_alu_op = 4'($urandom_range(9)); id_a_sel = 2'($urandom_range(3)); id_b_sel = 1'($urandom_range(1));
      id_reg_we = 1'($urandom_range(1)); id_mem_re = ($urandom_range(2) == 0); id_mem_we = ($urandom_range(3) == 0);
      mem_rd = 5'($urandom_range(7)); mem_reg_we = 1'($urandom_range(1)); mem_mem_re = 1'($urandom_range(1));
      mem_result = $urandom;
      wb_rd = 5'($urandom_range(7)); wb_reg_we = 1'($urandom_range(1)); wb_result = $urandom;
      ex_ready = ($urandom_range(3) != 0); flush = ($urandom_range(9) == 0);
      #1;
      pend = mv && mem_reg_we && mem_mem_re && mem_rd != 0 &&
             ((m.asel == 2'd0 && mem_rd == m.rs1) || ((m.bsel == 1'b0 || m.mwe) && mem_rd == m.rs2));
      e_valid = mv && !pend;
      free = !mv || (e_valid && ex_ready);
      lu = mv && m.mre && m.rd != 0 && m.rwe && id_valid && (id_rs1 == m.rd || id_rs2 == m.rd);
      e_ready = free && !lu && !flush;
      v1 = ref_fwd(m.rs1, m.d1);
      v2 = ref_fwd(m.rs2, m.d2);
      e_a = (m.asel == 2'd0) ? v1 : (m.asel == 2'd1) ? m.pc : 32'h0;
      e_b = m.bsel ? m.imm : v2;
      checks++; if (ex_valid !== e_valid) begin errors++; $display("FAIL rnd%0d_ex_valid: got %0b want %0b", i, ex_valid, e_valid); end
      checks++; if (id_ready !== e_ready) begin errors++; $display("FAIL rnd%0d_id_ready: got %0b want %0b", i, id_ready, e_ready); end
      checks++; if ({ex_reg_we, ex_mem_re, ex_mem_we} !== {m.rwe, m.mre, m.mwe}) begin errors++; $display("FAIL rnd%0d_flags: got %b want %b", i, {ex_reg_we, ex_mem_re, ex_mem_we}, {m.rwe, m.mre, m.mwe}); end
      if (e_valid) begin
        checks++; if (alu_a !== e_a) begin errors++; $display("FAIL rnd%0d_alu_a: got %h want %h", i, alu_a, e_a); end
        checks++; if (alu_b !== e_b) begin errors++; $display("FAIL rnd%0d_alu_b: got %h want %h", i, alu_b, e_b); end
        checks++; if (ex_store_data !== v2) begin errors++; $display("FAIL rnd%0d_store: got %h want %h", i, ex_store_data, v2); end
        checks++; if (alu_op !== m.op || ex_pc !== m.pc || ex_rd !== m.rd) begin errors++; $display("FAIL rnd%0d_side: got op=%0d pc=%h rd=%0d want %0d %h %0d", i, alu_op, ex_pc, ex_rd, m.op, m.pc, m.rd); end
      end
      // Advance the model by one clock using the inputs held across the edge.
      if (flush) begin
        mv = 0;
      end else if (free && lu) begin
        mv = 0; m.rwe = 0; m.mre = 0; m.mwe = 0;
      end else if (free) begin
        mv = id_valid;
        m = '{pc: id_pc, d1: id_rs1_data, d2: id_rs2_data, imm: id_imm, rs1: id_rs1, rs2: id_rs2,
              rd: id_rd, op: id_alu_op, asel: id_a_sel, bsel: id_b_sel, rwe: id_reg_we,
              mre: id_mem_re, mwe: id_mem_we};
      end else begin
        m.d1 = v1; m.d2 = v2;
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_use();
    test_fwd_priority();
    test_stall_refresh();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-delivery stage for the ALU; it sits directly upstream of the ALU in the EX stage.
- Captures decoded instructions from ID under a valid/ready handshake.
- Resolves RAW hazards by forwarding from MEM and WB, and detects load-use hazards, inserting bubbles.
- Presents final ALU operands a, b and the 4-bit op, plus sideband fields, to EX.

Parameters:
- XLEN, 32, datapath width (ALU operand width).
- RA_W, 5, register-address width.
- RESET_PC, 32'h0000_0000, reset value of the ex_pc register.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  branch/jump redirect; kills the EX slot and the incoming ID instruction.
- id_valid  in  1  ID holds a valid decoded instruction.
- id_ready  out  1  stage accepts the ID instruction this cycle.
- id_pc  in  XLEN  instruction PC.
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_rs1, id_rs2, id_rd  in  RA_W  register addresses.
- id_alu_op  in  4  ALU operation encoding (shared constants).
- id_a_sel  in  2  A source: 0=rs1, 1=pc, 2=zero; 3 is reserved and treated as zero.
- id_b_sel  in  1  B source: 0=rs2, 1=imm.
- id_reg_we, id_mem_re, id_mem_we  in  1  writeback enable, load, store.
- mem_rd  in  RA_W  destination register of the MEM-stage instruction.
- mem_reg_we, mem_mem_re  in  1  MEM-stage writeback enable and load flag.
- mem_result  in  XLEN  MEM-stage ALU result.
- wb_rd  in  RA_W  destination register of the WB-stage instruction.
- wb_reg_we  in  1  WB-stage writeback enable.
- wb_result  in  XLEN  WB-stage writeback value.
- ex_ready  in  1  EX/MEM accepts the EX instruction.
- ex_valid  out  1  EX slot valid and operands ready.
- alu_a, alu_b  out  XLEN  ALU operands.
- alu_op  out  4  ALU operation.
- ex_store_data  out  XLEN  forwarded rs2 value for stores.
- ex_pc  out  XLEN  PC of the EX instruction.
- ex_rd  out  RA_W  destination register of the EX instruction.
- ex_reg_we, ex_mem_re, ex_mem_we  out  1  registered control flags.

Behaviour:
Reset (rst_n=0, asynchronous):
- valid_q=0.
- All data, address and control registers = 0; ex_pc = RESET_PC.
- Outputs therefore: ex_valid=0, alu_op=0, ex_reg_we/ex_mem_re/ex_mem_we=0.
- Reset asserted mid-operation discards the slot with no partial state retained.

Slot rules:
- slot_free = !valid_q || (ex_valid && ex_ready).
- load_use = valid_q && ex_mem_re && ex_rd!=0 && ex_reg_we && id_valid && (id_rs1==ex_rd || id_rs2==ex_rd). Both rs fields are compared regardless of a_sel/b_sel; this is conservative.
- id_ready = slot_free && !load_use && !flush.

Next-state priority (each edge):
1. flush: valid_q<=0.
2. slot_free && load_use: bubble, valid_q<=0 and control flags cleared.
3. slot_free: capture all ID fields, valid_q<=id_valid.
4. Otherwise hold.

Forwarding (combinational, per operand r in {rs1, rs2}):
- Index 0 never forwards and always yields 0.
- Priority 1, MEM: mem_reg_we && !mem_mem_re && mem_rd==r gives mem_result.
- Priority 2, WB: wb_reg_we && wb_rd==r gives wb_result.
- Otherwise the stored value.
- Hold refresh: while valid_q && !(ex_valid && ex_ready), the stored rs1/rs2 data is overwritten each edge with its forwarded value, so a producer retiring during the stall is not lost.

Operand readiness:
- mem_pending = valid_q && mem_reg_we && mem_mem_re && mem_rd!=0 && mem_rd matches a used source.
- rs1 is used when a_sel=0; rs2 is used when b_sel=0 or ex_mem_we=1.
- ex_valid = valid_q && !mem_pending.

Operand muxes:
- alu_a = fwd_rs1 / ex_pc / 0 according to a_sel.
- alu_b = fwd_rs2 / imm according to b_sel.
- ex_store_data = fwd_rs2.

Latency:
- One cycle from ID handshake to ex_valid.
- Throughput of one instruction per cycle with no hazards.
- A load-use hazard costs exactly one bubble.

Simultaneous events:
- flush with ex_ready=0: the slot is still killed.
- flush with load_use: flush wins.
- Same rd in MEM and WB: MEM wins.

Decomposition:
- Shared package, extending the existing definitions, holds:
  - ALU op encodings (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND);
  - a_sel and b_sel enum constants;
  - a packed struct of the ID/EX control fields.
- One natural sub-module: fwd_unit, instantiated twice. It takes (rs, stored, mem_*, wb_*) and produces (value, pending).

Test Plan:
- Reset mid-stream: assert rst_n=0 with valid_q=1 -> ex_valid=0 immediately; alu_op=0; ex_pc=RESET_PC.
- Back-to-back ADD x3,x1,x2 then SUB x4,x3,x1, with MEM result 7 for x3 -> second instruction gives alu_a=7, no stall, id_ready held 1.
- LW x5 then ADD x6,x5,x0 -> id_ready=0 for one cycle, one bubble inserted; next cycle alu_a=wb_result (e.g. 0xDEAD_BEEF).
- MEM and WB both writing x8 (MEM 5, WB 9) -> alu_a=5; rs=x0 with MEM writing x0 -> alu_a=0.
- ex_ready=0 for 3 cycles while WB retires x2=0x55 -> after release alu_b=0x55; ID held and not duplicated.
- flush with ex_valid=1 and id_valid=1 -> next cycle ex_valid=0 and the ID instruction is not captured.
